udp_rx_unpack: RTL and testbench

- Receive-side counterpart of the GMII UDP/IP/MAC transmit path.
- Takes GMII receive bytes from the PHY and strips the preamble/SFD, Ethernet header, IPv4 header and UDP header.
- Filters frames on local MAC / IP / port.
- Streams the UDP payload bytes to the application with framing strobes and a per-packet status pulse.

---
 rtl/udp_rx_unpack.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_udp_rx_unpack.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_unpack.sv
// udp_rx_unpack
//   Receive-side GMII UDP/IPv4/Ethernet unpacker. Strips preamble/SFD, the
//   Ethernet, IPv4 and UDP headers, filters on local MAC/IP/port/protocol and
//   streams the UDP payload to the application with sof/eof strobes and a
//   one-cycle per-packet status pulse.
//
//   Optional feature macro: FCS_CHECK_EN
//     defined   - CRC-32 residue check over dest MAC .. last FCS byte gates pkt_ok
//     undefined - FCS bytes are absorbed unchecked
//
//   Ports:
//     clk, rst            125 MHz GMII rx clock, synchronous active-high reset
//     local_mac_addr      accepted destination MAC (broadcast too if ACCEPT_BCAST)
//     local_ip_addr       accepted destination IPv4 address
//     local_port          accepted UDP destination port
//     prot_type           accepted IPv4 protocol field
//     rx_dv, rxd, rx_er   GMII receive interface
//     app_rx_en/dat       registered payload byte stream
//     app_rx_sof/eof      first / last payload byte markers
//     pkt_done, pkt_ok    end-of-packet pulse and its status
//     rmt_ip_addr/port    source IP / UDP port of the last accepted packet
//     rx_busy             receiver not in IDLE
//     drop_cnt            saturating count of header-rejected frames
module udp_rx_unpack #(
   parameter int unsigned ACCEPT_BCAST = 1,
   parameter int unsigned DROP_CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [47:0]           local_mac_addr,
   input  logic [31:0]           local_ip_addr,
   input  logic [15:0]           local_port,
   input  logic [7:0]            prot_type,
   input  logic                  rx_dv,
   input  logic [7:0]            rxd,
   input  logic                  rx_er,
   output logic                  app_rx_en,
   output logic [7:0]            app_rx_dat,
   output logic                  app_rx_sof,
   output logic                  app_rx_eof,
   output logic                  pkt_done,
   output logic                  pkt_ok,
   output logic [31:0]           rmt_ip_addr,
   output logic [15:0]           rmt_port,
   output logic                  rx_busy,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam logic [2:0] S_WAIT_IDLE = 3'd0;
   localparam logic [2:0] S_IDLE      = 3'd1;
   localparam logic [2:0] S_PREAMBLE  = 3'd2;
   localparam logic [2:0] S_MAC_HDR   = 3'd3;
   localparam logic [2:0] S_IP_HDR    = 3'd4;
   localparam logic [2:0] S_UDP_HDR   = 3'd5;
   localparam logic [2:0] S_PAYLOAD   = 3'd6;
   localparam logic [2:0] S_TAIL      = 3'd7;

   logic [2:0]            state_q, state_d;
   logic [4:0]            byte_cnt_q, byte_cnt_d;
   logic [15:0]           pay_cnt_q, pay_cnt_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic                  ucast_ok_q, ucast_ok_d;
   logic                  bcast_ok_q, bcast_ok_d;
   logic                  zero_len_q, zero_len_d;
   logic                  first_q, first_d;
   logic                  err_pend_q, err_pend_d;
   logic [31:0]           ip_sh_q, ip_sh_d;
   logic [15:0]           port_sh_q, port_sh_d;
   logic                  app_rx_en_q, app_rx_en_d;
   logic [7:0]            app_rx_dat_q, app_rx_dat_d;
   logic                  app_rx_sof_q, app_rx_sof_d;
   logic                  app_rx_eof_q, app_rx_eof_d;
   logic                  pkt_done_q, pkt_done_d;
   logic                  pkt_ok_q, pkt_ok_d;
   logic [31:0]           rmt_ip_addr_q, rmt_ip_addr_d;
   logic [15:0]           rmt_port_q, rmt_port_d;
   logic                  rx_busy_q, rx_busy_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic                  hdr_drop;
   logic                  crc_ok;
   logic                  uc_now, bc_now;
   logic [7:0]            mac_byte, ip_byte;
   logic [15:0]           udp_len;

`ifdef FCS_CHECK_EN
   logic [31:0]           crc_q, crc_d;

   // Reflected CRC-32, one byte, LSB first.
   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   assign crc_ok = (crc_q == 32'hDEBB20E3);
`else
   assign crc_ok = 1'b1;
`endif

   always_comb begin
      mac_byte = 8'h00;
      case (byte_cnt_q[2:0])
         3'd0:    mac_byte = local_mac_addr[47:40];
         3'd1:    mac_byte = local_mac_addr[39:32];
         3'd2:    mac_byte = local_mac_addr[31:24];
         3'd3:    mac_byte = local_mac_addr[23:16];
         3'd4:    mac_byte = local_mac_addr[15:8];
         3'd5:    mac_byte = local_mac_addr[7:0];
         default: mac_byte = 8'h00;
      endcase
      ip_byte = 8'h00;
      case (byte_cnt_q)
         5'd16:   ip_byte = local_ip_addr[31:24];
         5'd17:   ip_byte = local_ip_addr[23:16];
         5'd18:   ip_byte = local_ip_addr[15:8];
         5'd19:   ip_byte = local_ip_addr[7:0];
         default: ip_byte = 8'h00;
      endcase
   end

   assign udp_len = {len_hi_q, rxd};
   // Unicast and broadcast matches are tracked separately so a frame is only
   // rejected once neither interpretation of the dest MAC can still succeed.
   assign uc_now  = ucast_ok_q && (rxd == mac_byte);
   assign bc_now  = bcast_ok_q && (rxd == 8'hFF);

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      pay_cnt_d     = pay_cnt_q;
      len_hi_d      = len_hi_q;
      ucast_ok_d    = ucast_ok_q;
      bcast_ok_d    = bcast_ok_q;
      zero_len_d    = zero_len_q;
      first_d       = first_q;
      err_pend_d    = err_pend_q;
      ip_sh_d       = ip_sh_q;
      port_sh_d     = port_sh_q;
      app_rx_en_d   = 1'b0;
      app_rx_dat_d  = app_rx_dat_q;
      app_rx_sof_d  = 1'b0;
      app_rx_eof_d  = 1'b0;
      pkt_done_d    = 1'b0;
      pkt_ok_d      = 1'b0;
      rmt_ip_addr_d = rmt_ip_addr_q;
      rmt_port_d    = rmt_port_q;
      drop_cnt_d    = drop_cnt_q;
      hdr_drop      = 1'b0;
`ifdef FCS_CHECK_EN
      crc_d         = crc_q;
`endif

      case (state_q)
         S_WAIT_IDLE: begin
            if (!rx_dv) begin
               state_d = S_IDLE;
               // Deferred failure report for a frame aborted by rx_er.
               if (err_pend_q) begin
                  pkt_done_d = 1'b1;
                  err_pend_d = 1'b0;
               end
            end
         end
         S_IDLE: begin
            if (rx_dv) begin
               if (rxd == 8'h55) state_d = S_PREAMBLE;
               else              hdr_drop = 1'b1;
            end
         end
         S_PREAMBLE: begin
            if (rx_dv && !rx_er && rxd == 8'h55) begin
               state_d = S_PREAMBLE;
            end else if (rx_dv && !rx_er && rxd == 8'hD5) begin
               state_d    = S_MAC_HDR;
               byte_cnt_d = '0;
               ucast_ok_d = 1'b1;
               bcast_ok_d = (ACCEPT_BCAST != 0);
`ifdef FCS_CHECK_EN
               crc_d      = '1;
`endif
            end else begin
               hdr_drop = 1'b1;
            end
         end
         S_MAC_HDR: begin
            if (!rx_dv || rx_er) begin
               hdr_drop = 1'b1;
            end else begin
`ifdef FCS_CHECK_EN
               crc_d = crc_next(crc_q, rxd);
`endif
               byte_cnt_d = byte_cnt_q + 5'd1;
               if (byte_cnt_q < 5'd6) begin
                  ucast_ok_d = uc_now;
                  bcast_ok_d = bc_now;
                  if (!(uc_now || bc_now)) hdr_drop = 1'b1;
               end
               if (byte_cnt_q == 5'd12 && rxd != 8'h08) hdr_drop = 1'b1;
               if (byte_cnt_q == 5'd13) begin
                  if (rxd != 8'h00) hdr_drop = 1'b1;
                  state_d    = S_IP_HDR;
                  byte_cnt_d = '0;
               end
            end
         end
         S_IP_HDR: begin
            if (!rx_dv || rx_er) begin
               hdr_drop = 1'b1;
            end else begin
`ifdef FCS_CHECK_EN
               crc_d = crc_next(crc_q, rxd);
`endif
               byte_cnt_d = byte_cnt_q + 5'd1;
               if (byte_cnt_q == 5'd0 && rxd != 8'h45)     hdr_drop = 1'b1;
               if (byte_cnt_q == 5'd9 && rxd != prot_type) hdr_drop = 1'b1;
               if (byte_cnt_q >= 5'd12 && byte_cnt_q <= 5'd15) ip_sh_d = {ip_sh_q[23:0], rxd};
               if (byte_cnt_q >= 5'd16 && rxd != ip_byte)  hdr_drop = 1'b1;
               if (byte_cnt_q == 5'd19) begin
                  state_d    = S_UDP_HDR;
                  byte_cnt_d = '0;
               end
            end
         end
         S_UDP_HDR: begin
            if (!rx_dv || rx_er) begin
               hdr_drop = 1'b1;
            end else begin
`ifdef FCS_CHECK_EN
               crc_d = crc_next(crc_q, rxd);
`endif
               byte_cnt_d = byte_cnt_q + 5'd1;
               case (byte_cnt_q)
                  5'd0, 5'd1: port_sh_d = {port_sh_q[7:0], rxd};
                  5'd2: if (rxd != local_port[15:8]) hdr_drop = 1'b1;
                  5'd3: if (rxd != local_port[7:0])  hdr_drop = 1'b1;
                  5'd4: len_hi_d = rxd;
                  5'd5: begin
                     if (udp_len < 16'd8) hdr_drop = 1'b1;
                     pay_cnt_d  = udp_len - 16'd8;
                     zero_len_d = (udp_len == 16'd8);
                  end
                  5'd7: begin
                     // Source address/port only become visible once the whole
                     // header has been accepted.
                     rmt_ip_addr_d = ip_sh_q;
                     rmt_port_d    = port_sh_q;
                     first_d       = 1'b1;
                     state_d       = zero_len_q ? S_TAIL : S_PAYLOAD;
                  end
                  default: ;
               endcase
            end
         end
         S_PAYLOAD: begin
            if (!rx_dv) begin
               pkt_done_d = 1'b1;
               state_d    = S_IDLE;
            end else if (rx_er) begin
               err_pend_d = 1'b1;
               state_d    = S_WAIT_IDLE;
            end else begin
`ifdef FCS_CHECK_EN
               crc_d = crc_next(crc_q, rxd);
`endif
               app_rx_en_d  = 1'b1;
               app_rx_dat_d = rxd;
               app_rx_sof_d = first_q;
               first_d      = 1'b0;
               pay_cnt_d    = pay_cnt_q - 16'd1;
               if (pay_cnt_q == 16'd1) begin
                  app_rx_eof_d = 1'b1;
                  state_d      = S_TAIL;
               end
            end
         end
         S_TAIL: begin
            if (!rx_dv) begin
               pkt_done_d = 1'b1;
               pkt_ok_d   = crc_ok;
               state_d    = S_IDLE;
            end else if (rx_er) begin
               err_pend_d = 1'b1;
               state_d    = S_WAIT_IDLE;
            end else begin
`ifdef FCS_CHECK_EN
               crc_d = crc_next(crc_q, rxd);
`endif
            end
         end
         default: state_d = S_WAIT_IDLE;
      endcase

      if (hdr_drop) begin
         state_d = S_WAIT_IDLE;
         if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end

      rx_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_WAIT_IDLE;
         byte_cnt_q    <= '0;
         pay_cnt_q     <= '0;
         len_hi_q      <= '0;
         ucast_ok_q    <= 1'b0;
         bcast_ok_q    <= 1'b0;
         zero_len_q    <= 1'b0;
         first_q       <= 1'b0;
         err_pend_q    <= 1'b0;
         ip_sh_q       <= '0;
         port_sh_q     <= '0;
         app_rx_en_q   <= 1'b0;
         app_rx_dat_q  <= '0;
         app_rx_sof_q  <= 1'b0;
         app_rx_eof_q  <= 1'b0;
         pkt_done_q    <= 1'b0;
         pkt_ok_q      <= 1'b0;
         rmt_ip_addr_q <= '0;
         rmt_port_q    <= '0;
         rx_busy_q     <= 1'b0;
         drop_cnt_q    <= '0;
`ifdef FCS_CHECK_EN
         crc_q         <= '1;
`endif
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         pay_cnt_q     <= pay_cnt_d;
         len_hi_q      <= len_hi_d;
         ucast_ok_q    <= ucast_ok_d;
         bcast_ok_q    <= bcast_ok_d;
         zero_len_q    <= zero_len_d;
         first_q       <= first_d;
         err_pend_q    <= err_pend_d;
         ip_sh_q       <= ip_sh_d;
         port_sh_q     <= port_sh_d;
         app_rx_en_q   <= app_rx_en_d;
         app_rx_dat_q  <= app_rx_dat_d;
         app_rx_sof_q  <= app_rx_sof_d;
         app_rx_eof_q  <= app_rx_eof_d;
         pkt_done_q    <= pkt_done_d;
         pkt_ok_q      <= pkt_ok_d;
         rmt_ip_addr_q <= rmt_ip_addr_d;
         rmt_port_q    <= rmt_port_d;
         rx_busy_q     <= rx_busy_d;
         drop_cnt_q    <= drop_cnt_d;
`ifdef FCS_CHECK_EN
         crc_q         <= crc_d;
`endif
      end
   end

   assign app_rx_en   = app_rx_en_q;
   assign app_rx_dat  = app_rx_dat_q;
   assign app_rx_sof  = app_rx_sof_q;
   assign app_rx_eof  = app_rx_eof_q;
   assign pkt_done    = pkt_done_q;
   assign pkt_ok      = pkt_ok_q;
   assign rmt_ip_addr = rmt_ip_addr_q;
   assign rmt_port    = rmt_port_q;
   assign rx_busy     = rx_busy_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_unpack.sv
// tb_udp_rx_unpack
//   Directed bench for udp_rx_unpack. Frames are assembled byte by byte with a
//   bench-side CRC-32 generator for the FCS; a negedge monitor collects the
//   payload stream and packet-end pulses, which are then checked against
//   hand-written expectations. A second instance (no broadcast, 2-bit drop
//   counter) shares the inputs to cover broadcast rejection and saturation.
module tb_udp_rx_unpack;

   localparam logic [47:0] LMAC  = 48'h02_11_22_33_44_55;
   localparam logic [31:0] LIP   = 32'hC0A8_0164;
   localparam logic [15:0] LPORT = 16'h1F90;
   localparam logic [7:0]  PROT  = 8'd17;
   localparam logic [31:0] SRC_IP = 32'hC0A8_010A;

`ifdef FCS_CHECK_EN
   localparam logic BAD_FCS_OK = 1'b0;
`else
   localparam logic BAD_FCS_OK = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_dv, rx_er;
   logic [7:0]  rxd;

   logic        app_rx_en, app_rx_sof, app_rx_eof, pkt_done, pkt_ok, rx_busy;
   logic [7:0]  app_rx_dat;
   logic [31:0] rmt_ip_addr;
   logic [15:0] rmt_port, drop_cnt;

   logic        b_en, b_sof, b_eof, b_done, b_ok, b_busy;
   logic [7:0]  b_dat;
   logic [31:0] b_rmt_ip;
   logic [15:0] b_rmt_port;
   logic [1:0]  b_drop_cnt;

   always #4 clk = ~clk;

   udp_rx_unpack dut (
      .clk(clk), .rst(rst),
      .local_mac_addr(LMAC), .local_ip_addr(LIP), .local_port(LPORT), .prot_type(PROT),
      .rx_dv(rx_dv), .rxd(rxd), .rx_er(rx_er),
      .app_rx_en(app_rx_en), .app_rx_dat(app_rx_dat), .app_rx_sof(app_rx_sof),
      .app_rx_eof(app_rx_eof), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
      .rmt_ip_addr(rmt_ip_addr), .rmt_port(rmt_port), .rx_busy(rx_busy), .drop_cnt(drop_cnt)
   );

   udp_rx_unpack #(.ACCEPT_BCAST(0), .DROP_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst),
      .local_mac_addr(LMAC), .local_ip_addr(LIP), .local_port(LPORT), .prot_type(PROT),
      .rx_dv(rx_dv), .rxd(rxd), .rx_er(rx_er),
      .app_rx_en(b_en), .app_rx_dat(b_dat), .app_rx_sof(b_sof),
      .app_rx_eof(b_eof), .pkt_done(b_done), .pkt_ok(b_ok),
      .rmt_ip_addr(b_rmt_ip), .rmt_port(b_rmt_port), .rx_busy(b_busy), .drop_cnt(b_drop_cnt)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor
   logic [7:0] obs_dat[$];
   bit         obs_sof[$];
   bit         obs_eof[$];
   int         done_cnt;
   logic       last_ok;

   always @(negedge clk) begin
      if (app_rx_en) begin
         obs_dat.push_back(app_rx_dat);
         obs_sof.push_back(app_rx_sof);
         obs_eof.push_back(app_rx_eof);
      end
      if (pkt_done) begin
         done_cnt++;
         last_ok = pkt_ok;
      end
   end

   task automatic clr_mon();
      obs_dat.delete();
      obs_sof.delete();
      obs_eof.delete();
      done_cnt = 0;
      last_ok  = 1'b0;
   endtask

   // Frame construction
   logic [7:0] frm[$];
   logic [7:0] pay[$];

   task automatic build(input logic [47:0] dmac, input logic [15:0] sport,
                        input logic [15:0] dport, input logic [15:0] ulen,
                        input logic [7:0] proto);
      logic [7:0]  body[$];
      logic [31:0] c;
      logic [15:0] tlen;
      tlen = ulen + 16'd20;
      for (int i = 5; i >= 0; i--) body.push_back(dmac[8*i +: 8]);
      body.push_back(8'h02); body.push_back(8'h00); body.push_back(8'h00);
      body.push_back(8'h00); body.push_back(8'h00); body.push_back(8'h01);
      body.push_back(8'h08); body.push_back(8'h00);
      body.push_back(8'h45); body.push_back(8'h00);
      body.push_back(tlen[15:8]); body.push_back(tlen[7:0]);
      body.push_back(8'h00); body.push_back(8'h00);
      body.push_back(8'h40); body.push_back(8'h00);
      body.push_back(8'h40); body.push_back(proto);
      body.push_back(8'h00); body.push_back(8'h00);
      for (int i = 3; i >= 0; i--) body.push_back(SRC_IP[8*i +: 8]);
      for (int i = 3; i >= 0; i--) body.push_back(LIP[8*i +: 8]);
      body.push_back(sport[15:8]); body.push_back(sport[7:0]);
      body.push_back(dport[15:8]); body.push_back(dport[7:0]);
      body.push_back(ulen[15:8]);  body.push_back(ulen[7:0]);
      body.push_back(8'h00); body.push_back(8'h00);
      foreach (pay[i]) body.push_back(pay[i]);
      while (body.size() < 60) body.push_back(8'h00);
      c = '1;
      foreach (body[i]) begin
         c = c ^ {24'd0, body[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      frm.delete();
      for (int i = 0; i < 7; i++) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      foreach (body[i]) frm.push_back(body[i]);
      frm.push_back(c[7:0]); frm.push_back(c[15:8]);
      frm.push_back(c[23:16]); frm.push_back(c[31:24]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rx_dv = 1'b0; rxd = 8'h00; rx_er = 1'b0; rst = 1'b0;
      end
   endtask

   // Frame index 50 is the first payload byte (8 preamble/SFD + 42 header bytes).
   task automatic send(input int stop_at, input int er_at, input int rst_at, input int idle_after);
      for (int i = 0; i < frm.size(); i++) begin
         if (i == stop_at) break;
         @(posedge clk); #1;
         rx_dv = 1'b1; rxd = frm[i];
         rx_er = (i == er_at);
         rst   = (i == rst_at);
      end
      idle(idle_after);
   endtask

   task automatic check_frame(input string tag, input int n_exp, input bit eof_exp,
                              input int ndone, input logic ok_exp);
      chk({tag, "_nbytes"}, obs_dat.size(), n_exp);
      for (int i = 0; i < obs_dat.size() && i < n_exp; i++) begin
         chk({tag, "_dat"}, obs_dat[i], pay[i]);
         chk({tag, "_sof"}, obs_sof[i], (i == 0));
         chk({tag, "_eof"}, obs_eof[i], (eof_exp && i == n_exp - 1));
      end
      chk({tag, "_done"}, done_cnt, ndone);
      if (ndone > 0) chk({tag, "_ok"}, last_ok, ok_exp);
   endtask

   int exp_drop, exp_drop_b;

   task automatic bump_drop(input bit a, input bit b);
      if (a) exp_drop++;
      if (b && exp_drop_b < 3) exp_drop_b++;
   endtask

   initial begin
      rst = 1'b1; rx_dv = 1'b0; rxd = 8'h00; rx_er = 1'b0;
      exp_drop = 0; exp_drop_b = 0;
      clr_mon();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en",     app_rx_en, 0);
      chk("rst_done",   pkt_done, 0);
      chk("rst_ok",     pkt_ok, 0);
      chk("rst_rmt_ip", rmt_ip_addr, 0);
      chk("rst_port",   rmt_port, 0);
      chk("rst_drop",   drop_cnt, 0);
      chk("rst_busy",   rx_busy, 0);
      idle(3);
      chk("idle_busy",  rx_busy, 0);

      // Nominal frame
      pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      build(LMAC, 16'h1234, LPORT, 16'd12, PROT);
      clr_mon(); send(-1, -1, -1, 4);
      check_frame("good", 4, 1, 1, 1'b1);
      chk("good_rmt_port", rmt_port, 16'h1234);
      chk("good_rmt_ip",   rmt_ip_addr, SRC_IP);
      chk("good_drop",     drop_cnt, 0);

      // Wrong destination port: rejected, remote port must hold
      build(LMAC, 16'h4321, LPORT + 16'd1, 16'd12, PROT);
      clr_mon(); send(-1, -1, -1, 4); bump_drop(1, 1);
      check_frame("badport", 0, 0, 0, 1'b0);
      chk("badport_drop",  drop_cnt, exp_drop);
      chk("badport_hold",  rmt_port, 16'h1234);

      // Truncation: L=1000, only 10 payload bytes
      pay.delete();
      for (int i = 0; i < 10; i++) pay.push_back(8'(i * 7 + 3));
      build(LMAC, 16'h1234, LPORT, 16'd1000, PROT);
      clr_mon(); send(60, -1, -1, 4);
      check_frame("trunc", 10, 0, 1, 1'b0);

      // rx_er on third payload byte of an L=16 frame
      pay.delete();
      for (int i = 0; i < 8; i++) pay.push_back(8'(8'hA0 + i));
      build(LMAC, 16'h1234, LPORT, 16'd16, PROT);
      clr_mon(); send(-1, 52, -1, 4);
      check_frame("rxer", 2, 0, 1, 1'b0);

      // Zero-length payload
      pay.delete();
      build(LMAC, 16'h1234, LPORT, 16'd8, PROT);
      clr_mon(); send(-1, -1, -1, 4);
      check_frame("zlen", 0, 0, 1, 1'b1);

      // One-byte payload
      pay = '{8'h5A};
      build(LMAC, 16'h1234, LPORT, 16'd9, PROT);
      clr_mon(); send(-1, -1, -1, 4);
      check_frame("one", 1, 1, 1, 1'b1);

      // Broadcast: accepted by dut, rejected by dut_b
      pay = '{8'h11, 8'h22, 8'h33, 8'h44};
      build(48'hFFFF_FFFF_FFFF, 16'h1234, LPORT, 16'd12, PROT);
      clr_mon(); send(-1, -1, -1, 4); bump_drop(0, 1);
      check_frame("bcast", 4, 1, 1, 1'b1);
      chk("bcast_drop_b", b_drop_cnt, exp_drop_b);

      // Wrong protocol, wrong MAC (twice): dut_b counter saturates
      build(LMAC, 16'h1234, LPORT, 16'd12, 8'd6);
      clr_mon(); send(-1, -1, -1, 3); bump_drop(1, 1);
      chk("proto_done", done_cnt, 0);
      build(48'h02_11_22_33_44_56, 16'h1234, LPORT, 16'd12, PROT);
      send(-1, -1, -1, 3); bump_drop(1, 1);
      send(-1, -1, -1, 3); bump_drop(1, 1);
      chk("mac_done",   done_cnt, 0);
      chk("sat_drop",   drop_cnt, exp_drop);
      chk("sat_drop_b", b_drop_cnt, 2'd3);

      // Back-to-back frames, single idle cycle between
      pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      build(LMAC, 16'h1234, LPORT, 16'd12, PROT);
      clr_mon(); send(-1, -1, -1, 1); send(-1, -1, -1, 4);
      chk("b2b_nbytes", obs_dat.size(), 8);
      chk("b2b_done",   done_cnt, 2);
      chk("b2b_ok",     last_ok, 1);
      if (obs_dat.size() == 8) chk("b2b_dat", obs_dat[4], 8'hDE);

      // Corrupted FCS
      frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
      clr_mon(); send(-1, -1, -1, 4);
      check_frame("badfcs", 4, 1, 1, BAD_FCS_OK);

      // Reset during payload, then a clean frame
      build(LMAC, 16'h1234, LPORT, 16'd12, PROT);
      clr_mon(); send(-1, -1, 52, 4);
      exp_drop = 0; exp_drop_b = 0;
      chk("abort_nbytes", obs_dat.size(), 2);
      chk("abort_done",   done_cnt, 0);
      chk("abort_drop",   drop_cnt, exp_drop);
      clr_mon(); send(-1, -1, -1, 4);
      check_frame("post_rst", 4, 1, 1, 1'b1);
      chk("end_busy", rx_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1);
   end

endmodule
